// File: rtl/fetch_stage.sv
// IF stage: PC, 1-cycle imem interface, IF/ID register, and a 1-entry hold buffer for stalls.
// Optional FETCH_PERF_EN adds saturating stall-cycle and flush counters.
module fetch_stage #(
  parameter int unsigned     P_AW       = 24,
  parameter int unsigned     P_IW       = 24,
  parameter logic [P_AW-1:0] P_RESET_PC = '0
) (
  input  logic            iw_clk,
  input  logic            iw_rst_n,
  input  logic            iw_stall,
  input  logic            iw_redirect,
  input  logic [P_AW-1:0] iw_redirect_pc,
  output logic [P_AW-1:0] ow_imem_addr,
  output logic            ow_imem_en,
  input  logic [P_IW-1:0] iw_imem_data,
  output logic [P_IW-1:0] ow_ifid_instr,
  output logic [P_AW-1:0] ow_ifid_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]     ow_perf_stall_cyc,
  output logic [31:0]     ow_perf_flush_cnt,
`endif
  output logic            ow_ifid_valid
);

  typedef enum logic {ST_RUN, ST_HOLD} state_e;

  state_e            state_q, state_d;
  logic [P_AW-1:0]   pc_q, pc_d;
  logic [P_AW-1:0]   fpc_q, fpc_d;
  logic              fvalid_q, fvalid_d;
  logic [P_IW-1:0]   hold_instr_q, hold_instr_d;
  logic [P_AW-1:0]   hold_pc_q, hold_pc_d;
  logic              hold_valid_q, hold_valid_d;
  logic [P_IW-1:0]   ifid_instr_q, ifid_instr_d;
  logic [P_AW-1:0]   ifid_pc_q, ifid_pc_d;
  logic              ifid_valid_q, ifid_valid_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fpc_d        = fpc_q;
    fvalid_d     = fvalid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_valid_d = hold_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    if (iw_redirect) begin
      pc_d         = iw_redirect_pc;
      fvalid_d     = 1'b0;
      hold_valid_d = 1'b0;
      ifid_valid_d = 1'b0;
      state_d      = ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (iw_stall) begin
        // Park the fetch already in flight so release needs no refetch.
        hold_instr_d = iw_imem_data;
        hold_pc_d    = fpc_q;
        hold_valid_d = fvalid_q;
        fvalid_d     = 1'b0;
        state_d      = ST_HOLD;
      end else begin
        ifid_instr_d = iw_imem_data;
        ifid_pc_d    = fpc_q;
        ifid_valid_d = fvalid_q;
        fpc_d        = pc_q;
        fvalid_d     = 1'b1;
        pc_d         = pc_q + 1'b1;
      end
    end else if (!iw_stall) begin
      ifid_instr_d = hold_instr_q;
      ifid_pc_d    = hold_pc_q;
      ifid_valid_d = hold_valid_q;
      hold_valid_d = 1'b0;
      fpc_d        = pc_q;
      fvalid_d     = 1'b1;
      pc_d         = pc_q + 1'b1;
      state_d      = ST_RUN;
    end
  end

  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      state_q      <= ST_RUN;
      pc_q         <= P_RESET_PC;
      fpc_q        <= '0;
      fvalid_q     <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      hold_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fpc_q        <= fpc_d;
      fvalid_q     <= fvalid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_valid_q <= hold_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign ow_imem_addr  = pc_q;
  assign ow_imem_en    = iw_rst_n & (~iw_stall | iw_redirect);
  assign ow_ifid_instr = ifid_instr_q;
  assign ow_ifid_pc    = ifid_pc_q;
  assign ow_ifid_valid = ifid_valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cyc_q, stall_cyc_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_cnt_d = flush_cnt_q;
    if (iw_stall && !iw_redirect && (stall_cyc_q != '1))
      stall_cyc_d = stall_cyc_q + 32'd1;
    if (iw_redirect && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ow_perf_stall_cyc = stall_cyc_q;
  assign ow_perf_flush_cnt = flush_cnt_q;
`endif

endmodule
